// File: rtl/falcon_pkg.sv
// Shared constants, state encoding and degree-dependent helpers for the
// Falcon key-generation norm checks.
package falcon_pkg;

  localparam int unsigned NORM_BOUND = 16823;
  localparam int unsigned SQN_W      = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_F,
    ST_RUN_G,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Bit bound on small-polynomial coefficients; only Falcon-512/1024 are used.
  function automatic int unsigned max_fg_bits(input int unsigned logn);
    return (logn == 9) ? 6 : 5;
  endfunction

endpackage

// File: rtl/poly_sq_acc.sv
// Two-stage square-and-accumulate: stage A registers x*x, stage B adds it
// into the running sum. clear zeroes the sum and drops any pending square.
module poly_sq_acc
  import falcon_pkg::*;
#(
  parameter int unsigned IN_W = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_x,
  output logic [SQN_W-1:0]       acc,
  output logic                   busy
);

  logic signed [2*IN_W-1:0] x_ext;
  logic signed [2*IN_W-1:0] prod;
  logic                     sq_valid_q, sq_valid_d;
  logic [SQN_W-1:0]         sq_q, sq_d;
  logic [SQN_W-1:0]         acc_q, acc_d;

  always_comb begin
    x_ext      = {{IN_W{in_x[IN_W-1]}}, in_x};
    prod       = x_ext * x_ext;
    sq_valid_d = in_valid && !clear;
    sq_d       = SQN_W'($unsigned(prod));
    acc_d      = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (sq_valid_q) begin
      acc_d = acc_q + sq_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_valid_q <= 1'b0;
      sq_q       <= '0;
      acc_q      <= '0;
    end else begin
      sq_valid_q <= sq_valid_d;
      sq_q       <= sq_d;
      acc_q      <= acc_d;
    end
  end

  assign acc  = acc_q;
  assign busy = sq_valid_q;

endmodule

// File: rtl/poly_small_norm_check.sv
// Consumes the f-then-g coefficient stream of the small-polynomial sampler,
// range-checks every coefficient and reports the squared norm with a verdict.
module poly_small_norm_check
  import falcon_pkg::*;
#(
  parameter int unsigned logn  = 9,
  parameter int unsigned f_bit = (logn == 9) ? 7 : 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    f_valid,
  input  logic signed [f_bit-1:0] f,
  output logic                    done,
  output logic                    pass,
  output logic [SQN_W-1:0]        sqnorm,
  output state_e                  dbg_state
);

  // Handshake: f_valid has no ready; every asserted cycle in RUN_F/RUN_G is one
  // coefficient. ena is honoured only in IDLE; done is a one-cycle verdict strobe.
  localparam logic [10:0]          LAST  = 11'((1 << logn) - 1);
  localparam int                   LIM   = 1 << (max_fg_bits(logn) - 1);
  localparam logic signed [f_bit:0] LIM_P = (f_bit + 1)'(LIM);
  localparam logic signed [f_bit:0] LIM_N = (f_bit + 1)'(-LIM);
  localparam logic [SQN_W-1:0]     BOUND = SQN_W'(NORM_BOUND);

  state_e                  state_q, state_d;
  logic [10:0]             cnt_q, cnt_d;
  logic                    s1_valid_q, s1_valid_d;
  logic signed [f_bit-1:0] s1_f_q, s1_f_d;
  logic                    s1_oor_q, s1_oor_d;
  logic                    bad_q, bad_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [SQN_W-1:0]        sqnorm_q, sqnorm_d;
  logic signed [f_bit:0]   f_ext;
  logic                    beat;
  logic                    acc_clear;
  logic [SQN_W-1:0]        acc;
  logic                    sq_busy;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bad_d      = bad_q;
    pass_d     = pass_q;
    sqnorm_d   = sqnorm_q;
    done_d     = 1'b0;
    acc_clear  = 1'b0;
    f_ext      = {f[f_bit-1], f};
    beat       = f_valid && ((state_q == ST_RUN_F) || (state_q == ST_RUN_G));
    s1_valid_d = beat;
    s1_f_d     = f;
    s1_oor_d   = (f_ext >= LIM_P) || (f_ext <= LIM_N);
    if (s1_valid_q && s1_oor_q) begin
      bad_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (ena) begin
          state_d   = ST_RUN_F;
          cnt_d     = '0;
          acc_clear = 1'b1;
          bad_d     = 1'b0;
          pass_d    = 1'b0;
          sqnorm_d  = '0;
        end
      end
      ST_RUN_F, ST_RUN_G: begin
        if (beat) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = (state_q == ST_RUN_F) ? ST_RUN_G : ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end
      end
      ST_DRAIN: begin
        // Last square has landed in the accumulator once both stages are idle.
        if (!s1_valid_q && !sq_busy) begin
          sqnorm_d = acc;
          pass_d   = !bad_q && (acc < BOUND);
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_f_q     <= '0;
      s1_oor_q   <= 1'b0;
      bad_q      <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      sqnorm_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_f_q     <= s1_f_d;
      s1_oor_q   <= s1_oor_d;
      bad_q      <= bad_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      sqnorm_q   <= sqnorm_d;
    end
  end

  poly_sq_acc #(.IN_W(f_bit)) u_sq_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (acc_clear),
    .in_valid (s1_valid_q),
    .in_x     (s1_f_q),
    .acc      (acc),
    .busy     (sq_busy)
  );

  assign done      = done_q;
  assign pass      = pass_q;
  assign sqnorm    = sqnorm_q;
  assign dbg_state = state_q;

endmodule

// File: doc/poly_small_norm_check.md
# poly_small_norm_check

Downstream consumer of the small-polynomial Gaussian sampler in the Falcon key-generation path. It takes the sampler's coefficient stream for f followed by g (2·n signed coefficients), checks every coefficient against the per-degree bit bound, and accumulates the exact squared norm ‖(f,g)‖². It then reports a single accept/reject verdict that keygen uses to decide whether to resample.

## Interface
- logn, 9, log2 of ring degree; n = 1<<logn (9 → Falcon-512, 10 → Falcon-1024)
- f_bit, (logn==9)?7:6, width of incoming signed coefficient, matches sampler output
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  one-cycle start pulse; arms the block for a new 2·n-coefficient frame
- f_valid  in  1  coefficient strobe from sampler; no backpressure, one coefficient per asserted cycle
- f  in  f_bit  signed coefficient (two's complement)
- done  out  1  one-cycle pulse, verdict valid
- pass  out  1  1 = all coefficients in range AND sqnorm < 16823; held until next ena
- sqnorm  out  24  unsigned ‖(f,g)‖², held until next ena

## Operation
- FSM: IDLE → RUN_F → RUN_G → DRAIN → DONE → IDLE.
- IDLE: f_valid ignored. ena moves to RUN_F and clears all of the following: coefficient counter, accumulator, range flag, pass, sqnorm.
- RUN_F / RUN_G: each f_valid beat is counted with an 11-bit counter. After n beats in RUN_F, go to RUN_G and reset the counter. After n beats in RUN_G, go to DRAIN.
- Range check per coefficient: lim = 1 << (max_fg_bits−1). max_fg_bits = 6 for logn 9 and 5 for logn 10, so lim = 32 / 16. Out of range iff f ≥ lim or f ≤ −lim. Any out-of-range coefficient sets a sticky bad flag.
- The stream is always fully consumed (all 2·n beats) even after bad is set, so framing with the upstream sampler stays aligned.
- Squaring: f² computed from sign-extended f. The maximum is (−64)² = 4096. The maximum total is 2048·4096 = 2²³, so the 24-bit accumulator cannot overflow. No saturation is needed.
- DRAIN: wait until the pipeline is empty, then latch sqnorm = acc and pass = !bad && acc < 16823.
- DONE: done = 1 for exactly one cycle, then return to IDLE.
- ena while not IDLE: ignored.
- f_valid in DRAIN/DONE: ignored. This is a protocol violation and is covered by a bench assertion.

## Timing
- Reset values: done=0, pass=0, sqnorm=0. State = IDLE; accumulator, counter and pipeline valids all 0.
- Pipeline: edge E0 samples f and the range compare into stage 1. E1 registers the square. E2 adds it into acc.
- Let E0 be the edge that samples the 2·n-th coefficient. At E3 sqnorm and pass are loaded and done rises; done falls at E4.
- The first coefficient may arrive in the cycle immediately after the ena edge.
- Gaps in f_valid are allowed and stall nothing. Back-to-back f_valid is supported every cycle.
- Reset mid-frame: everything returns to reset values immediately (asynchronous reset). The partial frame is discarded, and the next ena starts a clean frame.

## Structure
- Shared package falcon_pkg contains:
  - NORM_BOUND = 16823
  - max_fg_bits(logn) function
  - SQN_W = 24
  - FSM state enum
- One sub-module, poly_sq_acc, is natural: a two-stage square-and-accumulate with a clear input, reused later for the keygen norm checks.
- FSM, counter and range check stay in the top module.

## Test plan
- All 2·n coefficients = 0, logn 9 → done once, sqnorm=0, pass=1, at exactly 3 edges after the last beat.
- f = +1 ×512, g = 0 ×512 (logn 9) → sqnorm=512, pass=1.
- Boundary on the norm, logn 9, all coefficients in range:
  - 467 coefficients −6, 10 coefficients +1, rest 0 → sqnorm=16822, pass=1.
  - Same but one more +1 → sqnorm=16823, pass=0.
- f[5] = +32, all others 0 (logn 9) → sqnorm=1024, pass=0. Same with −31 → pass=1.
- Framing and stall handling, logn 10:
  - Random f_valid gaps, ena pulses injected mid-frame, all coefficients +15 → ena pulses ignored, sqnorm=2048·225=460800, pass=0.
  - Then rst_n low after 300 beats of the next frame → outputs 0, IDLE. A new ena plus a full all-zero frame → pass=1.
